// File: rtl/shift_pkg.sv
// Shared types for the universal shift register:
// operation modes and run-direction tracking.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_R    = 2'b01,
    DIR_L    = 2'b10
  } dir_t;

  function automatic dir_t mode_dir(
    input shift_mode_t m
  );
    return (m == MODE_SHL) ? DIR_L : DIR_R;
  endfunction

endpackage

// File: rtl/shift_run_counter.sv
// Counts consecutive same-direction shifts and pulses
// wrap_pulse for one cycle when a full word has moved.
module shift_run_counter
  import shift_pkg::*;
#(
  parameter  int NBITS_DATA = 4,
  localparam int NBITS_CNT  = $clog2(NBITS_DATA + 1)
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 shift_en,
  input  dir_t                 dir,
  input  logic                 clear,
  output logic [NBITS_CNT-1:0] count,
  output logic                 wrap_pulse
);

  localparam logic [NBITS_CNT-1:0] CNT_WRAP =
    NBITS_CNT'(NBITS_DATA);
  localparam logic [NBITS_CNT-1:0] CNT_ONE =
    NBITS_CNT'(1);

  logic [NBITS_CNT-1:0] count_q;
  logic [NBITS_CNT-1:0] count_d;
  logic [NBITS_CNT-1:0] inc;
  dir_t                 last_q;
  dir_t                 last_d;
  logic                 wrap_q;
  logic                 wrap_d;
  logic                 same_run;
  logic                 new_run;

  assign same_run = shift_en && !clear &&
    (last_q == dir || last_q == DIR_NONE);
  assign new_run  = shift_en && !clear && !same_run;
  assign inc      = count_q + CNT_ONE;

  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    wrap_d  = 1'b0;
    unique case (1'b1)
      clear: begin
        count_d = '0;
        last_d  = DIR_NONE;
      end
      same_run: begin
        last_d = dir;
        if (inc == CNT_WRAP) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = inc;
        end
      end
      // a direction change starts a fresh run of one
      new_run: begin
        count_d = CNT_ONE;
        last_d  = dir;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      last_q  <= DIR_NONE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count      = count_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift right/left, load,
// with serial taps and a word-complete pulse for SERDES use.
module shift_reg_universal
  import shift_pkg::*;
#(
  parameter int NBITS_DATA = 4,
  parameter int NBITS_CNT  = $clog2(NBITS_DATA + 1)
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  shift_mode_t           mode,
  input  logic [NBITS_DATA-1:0] data_in_parallel,
  input  logic                  data_in_serial_r,
  input  logic                  data_in_serial_l,
  output logic [NBITS_DATA-1:0] data_out,
  output logic                  serial_out_r,
  output logic                  serial_out_l,
  output logic [NBITS_CNT-1:0]  shift_count,
  output logic                  word_ready
);

  logic [NBITS_DATA-1:0] data_q;
  logic [NBITS_DATA-1:0] data_d;
  logic                  is_shr;
  logic                  is_shl;
  logic                  is_load;

  assign is_shr  = (mode == MODE_SHR);
  assign is_shl  = (mode == MODE_SHL);
  assign is_load = (mode == MODE_LOAD);

  always_comb begin
    data_d = data_q;
    unique case (1'b1)
      is_shr:  data_d = {data_in_serial_r,
                         data_q[NBITS_DATA-1:1]};
      is_shl:  data_d = {data_q[NBITS_DATA-2:0],
                         data_in_serial_l};
      is_load: data_d = data_in_parallel;
      default: ;
    endcase
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  shift_run_counter #(
    .NBITS_DATA (NBITS_DATA)
  ) u_run (
    .clk_2      (clk_2),
    .reset      (reset),
    .shift_en   (is_shr | is_shl),
    .dir        (mode_dir(mode)),
    .clear      (is_load),
    .count      (shift_count),
    .wrap_pulse (word_ready)
  );

  assign data_out     = data_q;
  assign serial_out_r = data_q[0];
  assign serial_out_l = data_q[NBITS_DATA-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Bench for shift_reg_universal: directed vector table,
// async reset sequence and randomized model comparison.
module tb_shift_reg_universal;
  import shift_pkg::*;

  localparam int N = 4;
  localparam int C = $clog2(N + 1);

  logic          clk_2 = 1'b0;
  logic          reset;
  shift_mode_t   mode;
  logic [N-1:0]  par;
  logic          sr;
  logic          sl;
  logic [N-1:0]  data_out;
  logic          serial_out_r;
  logic          serial_out_l;
  logic [C-1:0]  shift_count;
  logic          word_ready;

  int n_chk  = 0;
  int n_fail = 0;

  shift_reg_universal #(.NBITS_DATA(N)) dut (
    .clk_2            (clk_2),
    .reset            (reset),
    .mode             (mode),
    .data_in_parallel (par),
    .data_in_serial_r (sr),
    .data_in_serial_l (sl),
    .data_out         (data_out),
    .serial_out_r     (serial_out_r),
    .serial_out_l     (serial_out_l),
    .shift_count      (shift_count),
    .word_ready       (word_ready)
  );

  always #5 clk_2 = ~clk_2;

  always @(posedge clk_2) begin
    if (!reset && $isunknown(mode)) begin
      n_fail++;
      $display("FAIL mode_x: mode=%b required known", mode);
    end
  end

  typedef struct {
    shift_mode_t  m;
    logic [N-1:0] p;
    logic         r;
    logic         l;
    logic [N-1:0] ed;
    int           ec;
    logic         ew;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input shift_mode_t m,
                       input logic [N-1:0] p,
                       input logic r,
                       input logic l);
    @(negedge clk_2);
    mode = m;
    par  = p;
    sr   = r;
    sl   = l;
    @(posedge clk_2);
    #1;
  endtask

  task automatic add(input shift_mode_t m,
                     input logic [N-1:0] p,
                     input logic r, input logic l,
                     input logic [N-1:0] ed,
                     input int ec, input logic ew);
    vec_t v;
    v.m = m; v.p = p; v.r = r; v.l = l;
    v.ed = ed; v.ec = ec; v.ew = ew;
    vecs.push_back(v);
  endtask

  // reference model: data as an integer, run length as a
  // plain running total whose residue is the visible count
  int m_data;
  int m_run;
  int m_dir;
  int m_wr;

  task automatic model_step(input shift_mode_t m,
                            input int p,
                            input int r, input int l);
    int d;
    m_wr = 0;
    if (m == MODE_LOAD) begin
      m_data = p;
      m_run  = 0;
      m_dir  = 0;
    end else if (m == MODE_SHR || m == MODE_SHL) begin
      d = (m == MODE_SHR) ? 1 : 2;
      if (d == 1)
        m_data = (m_data / 2) + r * (1 << (N - 1));
      else
        m_data = ((m_data * 2) % (1 << N)) + l;
      m_run = (m_dir == 0 || m_dir == d) ? m_run + 1 : 1;
      m_dir = d;
      m_wr  = (m_run % N == 0) ? 1 : 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    mode  = MODE_HOLD;
    par   = '0;
    sr    = 1'b0;
    sl    = 1'b0;

    // async reset behaviour
    #2;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_cnt", 32'(shift_count), 32'h0);
    chk("rst_wr", 32'(word_ready), 32'h0);
    @(negedge clk_2);
    reset = 1'b0;
    drive(MODE_LOAD, 4'hA, 1'b0, 1'b0);
    chk("t1_load", 32'(data_out), 32'hA);
    drive(MODE_SHR, 4'h0, 1'b1, 1'b0);
    chk("t1_cnt1", 32'(shift_count), 32'h1);
    @(negedge clk_2);
    #2;
    reset = 1'b1;
    #1;
    chk("t1_async_data", 32'(data_out), 32'h0);
    chk("t1_async_cnt", 32'(shift_count), 32'h0);
    mode = MODE_LOAD;
    par  = 4'hF;
    @(posedge clk_2);
    #1;
    chk("t1_held_data", 32'(data_out), 32'h0);
    @(negedge clk_2);
    reset = 1'b0;
    mode  = MODE_HOLD;

    // test 2
    add(MODE_LOAD, 4'hA, 0, 0, 4'hA, 0, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hD, 1, 0);
    add(MODE_SHR,  4'h0, 0, 0, 4'h6, 2, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hB, 3, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hD, 0, 1);
    add(MODE_HOLD, 4'h0, 0, 0, 4'hD, 0, 0);
    // test 3
    add(MODE_LOAD, 4'h0, 0, 0, 4'h0, 0, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'h8, 1, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hC, 2, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hE, 3, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hF, 0, 1);
    add(MODE_SHR,  4'h0, 1, 0, 4'hF, 1, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hF, 2, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hF, 3, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hF, 0, 1);
    // load right after a pulse
    add(MODE_LOAD, 4'h3, 0, 0, 4'h3, 0, 0);
    // test 4
    add(MODE_SHR,  4'h0, 0, 0, 4'h1, 1, 0);
    add(MODE_SHR,  4'h0, 0, 0, 4'h0, 2, 0);
    add(MODE_SHL,  4'h0, 0, 1, 4'h1, 1, 0);
    // test 5
    add(MODE_LOAD, 4'h0, 0, 0, 4'h0, 0, 0);
    add(MODE_SHL,  4'h0, 0, 1, 4'h1, 1, 0);
    add(MODE_HOLD, 4'h0, 1, 1, 4'h1, 1, 0);
    add(MODE_HOLD, 4'h0, 1, 1, 4'h1, 1, 0);
    add(MODE_HOLD, 4'h0, 1, 1, 4'h1, 1, 0);
    add(MODE_SHL,  4'h0, 0, 0, 4'h2, 2, 0);
    add(MODE_SHL,  4'h0, 0, 1, 4'h5, 3, 0);
    add(MODE_SHL,  4'h0, 0, 0, 4'hA, 0, 1);
    add(MODE_HOLD, 4'h0, 0, 0, 4'hA, 0, 0);
    // test 6
    add(MODE_LOAD, 4'h0, 0, 0, 4'h0, 0, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'h8, 1, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hC, 2, 0);
    add(MODE_SHR,  4'h0, 1, 0, 4'hE, 3, 0);
    add(MODE_LOAD, 4'h5, 0, 0, 4'h5, 0, 0);
    add(MODE_SHR,  4'h0, 0, 0, 4'h2, 1, 0);
    add(MODE_SHR,  4'h0, 0, 0, 4'h1, 2, 0);
    add(MODE_SHR,  4'h0, 0, 0, 4'h0, 3, 0);
    add(MODE_SHR,  4'h0, 0, 0, 4'h0, 0, 1);
    add(MODE_HOLD, 4'h0, 0, 0, 4'h0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].m, vecs[i].p, vecs[i].r, vecs[i].l);
      chk($sformatf("vec%0d_data", i),
          32'(data_out), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_cnt", i),
          32'(shift_count), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_wr", i),
          32'(word_ready), 32'(vecs[i].ew));
      chk($sformatf("vec%0d_sor", i),
          32'(serial_out_r), 32'(vecs[i].ed[0]));
      chk($sformatf("vec%0d_sol", i),
          32'(serial_out_l), 32'(vecs[i].ed[N-1]));
    end

    // randomized run against the model
    m_data = 0; m_run = 0; m_dir = 0; m_wr = 0;
    model_step(MODE_LOAD, 0, 0, 0);
    drive(MODE_LOAD, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      shift_mode_t rm;
      int rp, rr, rl;
      // bias toward shifts so full words occur often
      case ($urandom_range(0, 9))
        0, 1:    rm = MODE_HOLD;
        2:       rm = MODE_LOAD;
        3, 4, 5: rm = MODE_SHR;
        default: rm = MODE_SHL;
      endcase
      rp = int'($urandom_range(0, (1 << N) - 1));
      rr = int'($urandom_range(0, 1));
      rl = int'($urandom_range(0, 1));
      model_step(rm, rp, rr, rl);
      drive(rm, N'(rp), rr[0], rl[0]);
      chk($sformatf("rnd%0d_data", i),
          32'(data_out), 32'(m_data));
      chk($sformatf("rnd%0d_cnt", i),
          32'(shift_count), 32'(m_run % N));
      chk($sformatf("rnd%0d_wr", i),
          32'(word_ready), 32'(m_wr));
      chk($sformatf("rnd%0d_sor", i),
          32'(serial_out_r), 32'(m_data % 2));
      chk($sformatf("rnd%0d_sol", i),
          32'(serial_out_l), 32'(m_data / (1 << (N - 1))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
